// File: rtl/line_fill_buffer.sv
// ============================================================================
// line_fill_buffer: assembles one 256-bit line from BEATS memory beats and
// early-forwards the missed 16-bit word.                          Rev 1.0
// ============================================================================
`default_nettype none

module line_fill_buffer #(
   parameter int BEAT_W = 64,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fill_req,
   input  logic [15:0]       fill_addr,
   output logic              pmem_read,
   output logic [15:0]       pmem_address,
   input  logic              pmem_resp,
   input  logic [BEAT_W-1:0] pmem_rdata,
   output logic              word_valid,
   output logic [15:0]       word,
   output logic              line_valid,
   output logic [255:0]      line_data,
   input  logic              line_ack,
   output logic              busy
);

   localparam int BEAT_IDX_W = $clog2(BEATS);
   localparam int BYTE_LG    = $clog2(BEAT_W / 8);
   localparam int BIT_LG     = $clog2(BEAT_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [BEAT_IDX_W-1:0] beat_q, beat_d;
   logic [15:5]           base_q, base_d;
   logic [4:0]            off_q, off_d;
   logic [255:0]          line_q, line_d;
   logic [15:0]           word_q, word_d;
   logic                  word_valid_q, word_valid_d;

   logic [BYTE_LG-2:0]    w_word_sel;
   logic                  w_is_miss_beat;
   logic                  w_unused;

   assign w_word_sel     = off_q[BYTE_LG-1:1];
   assign w_is_miss_beat = (beat_q == off_q[4:BYTE_LG]);
   // Byte-within-word bit is kept for completeness but never selects anything.
   assign w_unused       = off_q[0];

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      base_d       = base_q;
      off_d        = off_q;
      line_d       = line_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (fill_req) begin
               base_d  = fill_addr[15:5];
               off_d   = fill_addr[4:0];
               beat_d  = '0;
               line_d  = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            if (pmem_resp) begin
               line_d[{beat_q, {BIT_LG{1'b0}}} +: BEAT_W] = pmem_rdata;
               beat_d = beat_q + BEAT_IDX_W'(1);
               if (w_is_miss_beat) begin
                  word_valid_d = 1'b1;
                  word_d       = pmem_rdata[{w_word_sel, 4'b0000} +: 16];
               end
               if (beat_q == BEAT_IDX_W'(BEATS - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (line_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         base_q       <= '0;
         off_q        <= '0;
         line_q       <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         base_q       <= base_d;
         off_q        <= off_d;
         line_q       <= line_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign pmem_read    = (state_q == FILL);
   assign pmem_address = {base_q, beat_q, {BYTE_LG{1'b0}}};
   assign word_valid   = word_valid_q;
   assign word         = word_q;
   assign line_valid   = (state_q == DONE);
   assign line_data    = line_q;
   assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire
